// File: rtl/memory_initiator.sv
// Request-side master for a single-port memory: turns valid/ready commands into
// one-cycle memory strobes and returns read data (or a timeout error) on a response port.
module memory_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  memory_clk,
  input  logic                  memory_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  memory_en,
  output logic                  memory_wr,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_data_in,
  input  logic                  memory_vld_out,
  input  logic [DATA_WIDTH-1:0] memory_data_out
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_err_q, rsp_err_d;

  // Memory-side outputs are registered from the accept decision, so the ISSUE
  // cycle is exactly the cycle in which memory_en is high.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_data_d  = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          mem_en_d   = 1'b1;
          mem_wr_d   = req_wr;
          mem_addr_d = req_addr;
          mem_data_d = req_wr ? req_wdata : '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = mem_wr_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (memory_vld_out) begin
          rsp_data_d  = memory_data_out;
          rsp_err_d   = 1'b0;
          rsp_addr_d  = addr_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge memory_clk or negedge memory_rst) begin
    if (!memory_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Gate with reset so ready drops the moment reset asserts.
  assign req_ready      = (state_q == IDLE) & memory_rst;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_err        = rsp_err_q;
  assign memory_en      = mem_en_q;
  assign memory_wr      = mem_wr_q;
  assign memory_addr    = mem_addr_q;
  assign memory_data_in = mem_data_q;

endmodule
